// File: rtl/logic_unit_serial_pkg.sv
// rtl/logic_unit_serial_pkg.sv - shared op codes and FSM encoding for the slice-serial logic unit
package logic_unit_pkg;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;
    localparam logic [1:0] OP_NOR = 2'b11;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

endpackage

// File: rtl/logic_unit_serial_if.sv
// rtl/logic_unit_serial_if.sv - request/response bundle for the slice-serial logic unit
//   start/op/a/b : request side, driven by the master
//   busy/done/r/zero : status and result, driven by the unit
interface logic_unit_serial_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] r;
    logic             zero;

    modport master (
        output start, op, a, b,
        input  busy, done, r, zero
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, r, zero
    );
endinterface

// File: rtl/logic_unit_serial_slice.sv
// rtl/logic_unit_serial_slice.sv - combinational SLICE-bit AND/OR/XOR/NOR
//   op     : operation code
//   x0, x1 : operand slices
//   y      : op(x0, x1)
module logic_slice
    import logic_unit_pkg::*;
#(
    parameter int SLICE = 8
) (
    input  logic [1:0]       op,
    input  logic [SLICE-1:0] x0,
    input  logic [SLICE-1:0] x1,
    output logic [SLICE-1:0] y
);

    always_comb begin
        y = '0;
        case (op)
            OP_AND:  y = x0 & x1;
            OP_OR:   y = x0 | x1;
            OP_XOR:  y = x0 ^ x1;
            default: y = ~(x0 | x1);
        endcase
    end

endmodule

// File: rtl/logic_unit_serial.sv
// rtl/logic_unit_serial.sv - slice-serial bitwise logic unit with start/busy/done handshake
//   clk, rst : clock, asynchronous active-high reset
//   bus      : start/op/a/b request, busy/done/r/zero status and result
module logic_unit_serial
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    logic_unit_serial_if.slave   bus
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(NSLICE - 1);
    localparam logic [WIDTH-1:0] SLICE_MASK = WIDTH'({SLICE{1'b1}});

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             zero_q, zero_d;
    logic             done_q, done_d;

    logic [31:0]      sh_amt;
    logic [SLICE-1:0] x0, x1, y;
    logic [WIDTH-1:0] acc_ins;

    // Slice selection by shifting keeps the select logic width-clean for any SLICE,
    // including SLICE == WIDTH where the shift is always zero.
    always_comb begin
        sh_amt  = 32'(cnt_q) * 32'(SLICE);
        x0      = SLICE'(a_q >> sh_amt);
        x1      = SLICE'(b_q >> sh_amt);
        acc_ins = (acc_q & ~(SLICE_MASK << sh_amt)) | (WIDTH'(y) << sh_amt);
    end

    logic_slice #(.SLICE(SLICE)) u_slice (
        .op (op_q),
        .x0 (x0),
        .x1 (x1),
        .y  (y)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        r_d     = r_q;
        zero_d  = zero_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    op_d    = bus.op;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                acc_d = acc_ins;
                if (cnt_q == CNT_LAST) begin
                    // Publish the full word including the slice computed this cycle.
                    r_d     = acc_ins;
                    zero_d  = (acc_ins == '0);
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            r_q     <= '0;
            zero_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            r_q     <= r_d;
            zero_q  <= zero_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy = (state_q == ST_RUN);
    assign bus.done = done_q;
    assign bus.r    = r_q;
    assign bus.zero = zero_q;

endmodule

// File: tb/tb_logic_unit_serial.sv
// tb/tb_logic_unit_serial.sv - scoreboard bench for three slice-serial logic unit instances
module tb_logic_unit_serial;
    import logic_unit_pkg::*;

    typedef struct {
        logic [31:0] r;
        logic        zero;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    exp_t        sb [3][$];
    int          ns [3] = '{4, 1, 32};
    logic [31:0] last_r [3] = '{32'h0, 32'h0, 32'h0};

    logic_unit_serial_if #(.WIDTH(32)) if0 ();
    logic_unit_serial_if #(.WIDTH(32)) if1 ();
    logic_unit_serial_if #(.WIDTH(32)) if2 ();

    logic_unit_serial #(.WIDTH(32), .SLICE(8))  dut0 (.clk(clk), .rst(rst), .bus(if0));
    logic_unit_serial #(.WIDTH(32), .SLICE(32)) dut1 (.clk(clk), .rst(rst), .bus(if1));
    logic_unit_serial #(.WIDTH(32), .SLICE(1))  dut2 (.clk(clk), .rst(rst), .bus(if2));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            default: return ~(a | b);
        endcase
    endfunction

    function automatic logic get_done(input int d);
        case (d)
            0:       return if0.done;
            1:       return if1.done;
            default: return if2.done;
        endcase
    endfunction

    function automatic logic get_busy(input int d);
        case (d)
            0:       return if0.busy;
            1:       return if1.busy;
            default: return if2.busy;
        endcase
    endfunction

    function automatic logic get_zero(input int d);
        case (d)
            0:       return if0.zero;
            1:       return if1.zero;
            default: return if2.zero;
        endcase
    endfunction

    function automatic logic [31:0] get_r(input int d);
        case (d)
            0:       return if0.r;
            1:       return if1.r;
            default: return if2.r;
        endcase
    endfunction

    task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d @cyc %0d: got %h expected %h", name, d, cyc, act, exp);
        end
    endtask

    task automatic drive(input int d, input logic s, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        case (d)
            0:       begin if0.start = s; if0.op = o; if0.a = x; if0.b = y; end
            1:       begin if1.start = s; if1.op = o; if1.a = x; if1.b = y; end
            default: begin if2.start = s; if2.op = o; if2.a = x; if2.b = y; end
        endcase
    endtask

    task automatic set_start(input int d, input logic s);
        case (d)
            0:       if0.start = s;
            1:       if1.start = s;
            default: if2.start = s;
        endcase
    endtask

    // Called at a negedge while the unit is idle; the next posedge accepts it.
    task automatic start_op(input int d, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        exp_t e;
        drive(d, 1'b1, o, x, y);
        e.r    = model(o, x, y);
        e.zero = (e.r == 32'h0);
        e.cyc  = cyc + 1 + ns[d];
        sb[d].push_back(e);
    endtask

    // Returns at the negedge where done is visible; optionally disturbs inputs while busy.
    task automatic wait_done(input int d, input bit noise);
        int nb   = 0;
        bit seen = 1'b0;
        for (int i = 0; i < ns[d] + 4 && !seen; i++) begin
            @(negedge clk);
            if (get_done(d)) begin
                seen = 1'b1;
            end else begin
                if (get_busy(d)) nb++;
                if (noise && get_busy(d))
                    drive(d, 1'($urandom_range(0, 1)), 2'($urandom), $urandom, $urandom);
                else
                    set_start(d, 1'b0);
            end
        end
        set_start(d, 1'b0);
        chk("done_seen", d, 32'(seen), 32'd1);
        chk("busy_cycles", d, nb, ns[d]);
    endtask

    task automatic idle(input int d, input int n);
        set_start(d, 1'b0);
        repeat (n) @(negedge clk);
        chk("r_hold", d, get_r(d), last_r[d]);
        chk("busy_idle", d, 32'(get_busy(d)), 32'd0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        for (int d = 0; d < 3; d++) begin
            if (get_done(d)) begin
                if (sb[d].size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done dut%0d @cyc %0d: got done=1 expected 0", d, cyc);
                end else begin
                    e = sb[d].pop_front();
                    chk("result", d, get_r(d), e.r);
                    chk("zero", d, 32'(get_zero(d)), 32'(e.zero));
                    chk("latency", d, cyc, e.cyc);
                    last_r[d] = e.r;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int d = 0; d < 3; d++) drive(d, 1'b0, 2'b00, 32'h0, 32'h0);
        #1;
        for (int d = 0; d < 3; d++) begin
            chk("rst_busy", d, 32'(get_busy(d)), 32'd0);
            chk("rst_done", d, 32'(get_done(d)), 32'd0);
            chk("rst_r", d, get_r(d), 32'h0);
            chk("rst_zero", d, 32'(get_zero(d)), 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        start_op(0, OP_NOR, 32'hAAAA_AAAA, 32'h5555_5555);
        wait_done(0, 1'b0);
        idle(0, 2);

        start_op(0, OP_NOR, 32'h0000_0000, 32'h0000_0000);
        wait_done(0, 1'b0);
        start_op(0, OP_AND, 32'hFFFF_FFFF, 32'h0000_FFFF);
        wait_done(0, 1'b0);
        idle(0, 2);

        start_op(0, OP_XOR, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(0, 1'b1);
        idle(0, 3);

        start_op(0, OP_OR, 32'h1234_0000, 32'h0000_5678);
        @(negedge clk);
        set_start(0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_busy", 0, 32'(get_busy(0)), 32'd0);
        chk("abort_done", 0, 32'(get_done(0)), 32'd0);
        chk("abort_r", 0, get_r(0), 32'h0);
        sb[0].delete();
        for (int d = 0; d < 3; d++) last_r[d] = 32'h0;
        @(negedge clk);
        rst = 1'b0;
        idle(0, 8);
        start_op(0, OP_OR, 32'h1234_0000, 32'h0000_5678);
        wait_done(0, 1'b0);
        idle(0, 2);

        start_op(1, OP_NOR, 32'hFFFF_FFFF, 32'h0000_0000);
        wait_done(1, 1'b0);
        idle(1, 2);

        start_op(2, OP_AND, 32'h8000_0001, 32'hFFFF_FFFF);
        wait_done(2, 1'b0);
        idle(2, 2);

        for (int d = 0; d < 3; d++) begin
            for (int n = 0; n < ((d == 2) ? 8 : 30); n++) begin
                logic [31:0] x, y;
                x = $urandom;
                y = ($urandom_range(0, 3) == 0) ? x : $urandom;
                if ($urandom_range(0, 5) == 0) x = 32'h0;
                start_op(d, 2'($urandom), x, y);
                wait_done(d, 1'($urandom_range(0, 1)));
                if ($urandom_range(0, 2) == 0) idle(d, $urandom_range(1, 3));
            end
            idle(d, 2);
        end

        repeat (5) @(negedge clk);
        for (int d = 0; d < 3; d++) chk("sb_empty", d, sb[d].size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/logic_unit_serial.md
Name: logic_unit_serial

Overview:
- Parametrised, slice-serial bitwise logic unit (AND/OR/XOR/NOR) for the Mini-MIPS datapath.
- Generalises the combinational 32-bit NOR to any width and op, with a start/busy/done handshake and a registered result plus zero flag.
- Processes SLICE bits per clock, so the ALU can trade area against latency.

Parameters:
- WIDTH, 32, operand/result width in bits.
- SLICE, 8, bits processed per cycle. Must divide WIDTH exactly.
- NSLICE (localparam), WIDTH/SLICE, cycles per operation.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  request; sampled only while idle
- op  in  2  operation: 00 AND, 01 OR, 10 XOR, 11 NOR
- a  in  WIDTH  operand A; captured on accepted start
- b  in  WIDTH  operand B; captured on accepted start
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse; r and zero are valid
- r  out  WIDTH  result
- zero  out  1  high when result is all zeros

Behaviour:
- Reset (asynchronous, any state): state=IDLE, busy=0, done=0, r=0, zero=0, slice counter=0, operand registers=0.
- States: IDLE, RUN.
- IDLE:
  - done is a single-cycle pulse and may only be high in IDLE, in the first cycle after RUN exits.
  - start=1 at an edge: latch a, b and op into internal registers; counter=0; go to RUN; busy=1 after that edge.
  - done is cleared on this same edge.
- RUN, at each edge:
  - Compute slice k = op(a_q[k*SLICE +: SLICE], b_q[k*SLICE +: SLICE]), slice 0 is the LSB.
  - Write slice k into the internal accumulator; counter++.
- On the edge where k == NSLICE-1:
  - r <= full accumulator including the final slice.
  - zero <= (that value == 0).
  - done <= 1, busy <= 0; go to IDLE.
- Latency: start is sampled at edge E0. done and r are valid after edge E_NSLICE, i.e. NSLICE cycles later. With SLICE=WIDTH this is 1 cycle.
- Back-to-back: start high in the cycle done is visible is accepted. Throughput is one operation per NSLICE cycles.
- r and zero hold their last values until the next completion. They never show partial results.
- start while busy: ignored. It is not queued and has no effect on the operation in flight.
- Changes on a, b or op while busy: no effect, because the captured copies are used.
- Reset mid-RUN: the operation is aborted. No done pulse is produced and r=0.
- Counter width is clog2(NSLICE), minimum 1. The counter resets to 0 on entry to RUN and never wraps inside RUN.

Decomposition:
- Package logic_unit_pkg:
  - op code constants OP_AND=2'b00, OP_OR=2'b01, OP_XOR=2'b10, OP_NOR=2'b11.
  - state encoding ST_IDLE, ST_RUN.
- One sub-module, logic_slice #(SLICE): purely combinational (y = op(x0, x1)), instantiated once and fed by the counter-selected slices.
- The FSM, counter and registers stay in logic_unit_serial.

Test Plan (WIDTH=32, SLICE=8 unless stated):
- NOR, a=AAAA_AAAA, b=5555_5555 -> done exactly 4 cycles after start; r=0000_0000, zero=1; busy high for 4 cycles.
- NOR, a=b=0000_0000 -> r=FFFF_FFFF, zero=0. Then back-to-back AND, a=FFFF_FFFF, b=0000_FFFF, with start in the done cycle -> r=0000_FFFF after 4 more cycles.
- XOR, a=FFFF_FFFF, b=FFFF_FFFF. Change a and b, and pulse start, during busy -> r=0000_0000, zero=1; only one done pulse.
- OR, a=1234_0000, b=0000_5678. Assert rst at cycle 2 of RUN -> busy=0, done=0, r=0 immediately; no done afterwards. A new start completes normally with r=1234_5678.
- SLICE=32 instance, NOR, a=FFFF_FFFF, b=0000_0000 -> done 1 cycle after start; r=0000_0000, zero=1.
- SLICE=1 instance, AND, a=8000_0001, b=FFFF_FFFF -> done after 32 cycles; r=8000_0001; exercises the full counter range.
